// File: rtl/ctu_sync_pkg.sv
// Shared types and reset constants for the CMP-domain sync pulse generator.
package ctu_sync_pkg;

    // Width of every ratio/offset field; a ratio value r gives a period of r+1 cycles.
    localparam int SYNC_CNT_W = 4;

    // Reset configuration: jbus period 4, dram period 8.
    localparam logic [SYNC_CNT_W-1:0] JBUS_RATIO_DEF  = 4'd3;
    localparam logic [SYNC_CNT_W-1:0] JBUS_RX_OFS_DEF = 4'd0;
    localparam logic [SYNC_CNT_W-1:0] JBUS_TX_OFS_DEF = 4'd2;
    localparam logic [SYNC_CNT_W-1:0] DRAM_RATIO_DEF  = 4'd7;
    localparam logic [SYNC_CNT_W-1:0] DRAM_RX_OFS_DEF = 4'd0;
    localparam logic [SYNC_CNT_W-1:0] DRAM_TX_OFS_DEF = 4'd4;

    // Controller state: OFF holds counters at zero, RUN free-runs,
    // PEND free-runs while a new config waits for the common boundary.
    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } sync_state_t;

    // One divider channel's configuration.
    typedef struct packed {
        logic [SYNC_CNT_W-1:0] ratio;
        logic [SYNC_CNT_W-1:0] rx_ofs;
        logic [SYNC_CNT_W-1:0] tx_ofs;
    } chan_cfg_t;

    // A channel config is usable when the period is at least two cycles
    // and both phase offsets land inside that period.
    function automatic logic chan_cfg_legal(input chan_cfg_t c);
        return (c.ratio != '0) && (c.rx_ofs <= c.ratio) && (c.tx_ofs <= c.ratio);
    endfunction

    // Pack three raw fields into a channel config.
    function automatic chan_cfg_t chan_cfg_make(
        input logic [SYNC_CNT_W-1:0] ratio,
        input logic [SYNC_CNT_W-1:0] rx_ofs,
        input logic [SYNC_CNT_W-1:0] tx_ofs
    );
        chan_cfg_t c;
        c.ratio  = ratio;
        c.rx_ofs = rx_ofs;
        c.tx_ofs = tx_ofs;
        return c;
    endfunction

endpackage

// File: rtl/ctu_sync_div_chan.sv
// One programmable ratio divider: a 0..ratio wrapping counter plus the
// registered rx/tx phase compares that produce one-cycle sync pulses.
module ctu_sync_div_chan
    import ctu_sync_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_clear,
    input  logic      i_advance,
    input  chan_cfg_t i_cfg,
    output logic      o_term,
    output logic      o_rx,
    output logic      o_tx
);

    logic [SYNC_CNT_W-1:0] r_cnt;
    logic                  r_rx;
    logic                  r_tx;
    logic                  w_at_term;
    logic                  w_rx_hit;
    logic                  w_tx_hit;

    // The >= keeps the counter bounded even if it ever sits above a ratio.
    assign w_at_term = (r_cnt >= i_cfg.ratio);
    assign w_rx_hit  = (r_cnt == i_cfg.rx_ofs);
    assign w_tx_hit  = (r_cnt == i_cfg.tx_ofs);

    // Phase counter: cleared on request, otherwise counts 0..ratio and wraps.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (w_at_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Registered offset compares: a pulse appears the cycle after the
    // counter matches its offset, and only while the channel is advancing.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx <= 1'b0;
            r_tx <= 1'b0;
        end else begin
            r_rx <= i_advance && w_rx_hit;
            r_tx <= i_advance && w_tx_hit;
        end
    end

    assign o_term = (r_cnt == i_cfg.ratio);
    assign o_rx   = r_rx;
    assign o_tx   = r_tx;

endmodule

// File: rtl/ctu_sync_pulse_ctl.sv
// Global sync pulse controller in the CMP clock domain. Two divider channels
// (jbus, dram) produce rx/tx sync pulses; a small FSM accepts new divider
// configurations and swaps them in only at a common period boundary so that
// no downstream cluster ever sees a truncated or doubled slow period.
// CNT_W must match the field width of ctu_sync_pkg::chan_cfg_t.
module ctu_sync_pulse_ctl #(
    parameter int                 CNT_W           = ctu_sync_pkg::SYNC_CNT_W,
    parameter logic [CNT_W-1:0]   JBUS_RATIO_DEF  = ctu_sync_pkg::JBUS_RATIO_DEF,
    parameter logic [CNT_W-1:0]   JBUS_RX_OFS_DEF = ctu_sync_pkg::JBUS_RX_OFS_DEF,
    parameter logic [CNT_W-1:0]   JBUS_TX_OFS_DEF = ctu_sync_pkg::JBUS_TX_OFS_DEF,
    parameter logic [CNT_W-1:0]   DRAM_RATIO_DEF  = ctu_sync_pkg::DRAM_RATIO_DEF,
    parameter logic [CNT_W-1:0]   DRAM_RX_OFS_DEF = ctu_sync_pkg::DRAM_RX_OFS_DEF,
    parameter logic [CNT_W-1:0]   DRAM_TX_OFS_DEF = ctu_sync_pkg::DRAM_TX_OFS_DEF
) (
    input  logic             cmp_rclk,
    input  logic             cmp_arst,
    input  logic             en,
    input  logic             cfg_vld,
    output logic             cfg_rdy,
    input  logic [CNT_W-1:0] cfg_jbus_ratio,
    input  logic [CNT_W-1:0] cfg_jbus_rx_ofs,
    input  logic [CNT_W-1:0] cfg_jbus_tx_ofs,
    input  logic [CNT_W-1:0] cfg_dram_ratio,
    input  logic [CNT_W-1:0] cfg_dram_rx_ofs,
    input  logic [CNT_W-1:0] cfg_dram_tx_ofs,
    output logic             jbus_rx_sync_global,
    output logic             jbus_tx_sync_global,
    output logic             dram_rx_sync_global,
    output logic             dram_tx_sync_global,
    output logic             sync_running,
    output logic             cfg_err
);

    import ctu_sync_pkg::*;

    // Reset-time configuration of each channel.
    localparam chan_cfg_t JBUS_CFG_RST = {JBUS_RATIO_DEF, JBUS_RX_OFS_DEF, JBUS_TX_OFS_DEF};
    localparam chan_cfg_t DRAM_CFG_RST = {DRAM_RATIO_DEF, DRAM_RX_OFS_DEF, DRAM_TX_OFS_DEF};

    sync_state_t r_state;
    logic        r_cfg_rdy;
    logic        r_cfg_err;
    chan_cfg_t   r_jbus_act;
    chan_cfg_t   r_dram_act;
    chan_cfg_t   r_jbus_shd;
    chan_cfg_t   r_dram_shd;

    chan_cfg_t   w_jbus_offer;
    chan_cfg_t   w_dram_offer;
    logic        w_hs;
    logic        w_legal;
    logic        w_accept;
    logic        w_running;
    logic        w_advance;
    logic        w_boundary;
    logic        w_clear;
    logic        w_jbus_term;
    logic        w_dram_term;

    // Offered configuration and its legality.
    assign w_jbus_offer = chan_cfg_make(cfg_jbus_ratio, cfg_jbus_rx_ofs, cfg_jbus_tx_ofs);
    assign w_dram_offer = chan_cfg_make(cfg_dram_ratio, cfg_dram_rx_ofs, cfg_dram_tx_ofs);
    assign w_legal      = chan_cfg_legal(w_jbus_offer) && chan_cfg_legal(w_dram_offer);

    // An illegal config still completes the handshake; it is simply dropped.
    assign w_hs     = cfg_vld && r_cfg_rdy;
    assign w_accept = w_hs && w_legal;

    // Channels advance only while running and enabled. Dropping en clears the
    // counters at the very next edge and stops new pulses from being captured.
    assign w_running  = (r_state != OFF);
    assign w_advance  = w_running && en;
    assign w_boundary = (r_state == PEND) && w_jbus_term && w_dram_term;
    assign w_clear    = !w_advance || w_boundary;

    ctu_sync_div_chan u_jbus (
        .i_clk     (cmp_rclk),
        .i_rst     (cmp_arst),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .i_cfg     (r_jbus_act),
        .o_term    (w_jbus_term),
        .o_rx      (jbus_rx_sync_global),
        .o_tx      (jbus_tx_sync_global)
    );

    ctu_sync_div_chan u_dram (
        .i_clk     (cmp_rclk),
        .i_rst     (cmp_arst),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .i_cfg     (r_dram_act),
        .o_term    (w_dram_term),
        .o_rx      (dram_rx_sync_global),
        .o_tx      (dram_tx_sync_global)
    );

    // Control FSM: handshake, shadow capture and boundary-aligned config swap.
    always_ff @(posedge cmp_rclk or posedge cmp_arst) begin
        if (cmp_arst) begin
            r_state    <= OFF;
            r_cfg_rdy  <= 1'b1;
            r_cfg_err  <= 1'b0;
            r_jbus_act <= JBUS_CFG_RST;
            r_dram_act <= DRAM_CFG_RST;
            r_jbus_shd <= JBUS_CFG_RST;
            r_dram_shd <= DRAM_CFG_RST;
        end else begin
            r_cfg_err <= w_hs && !w_legal;
            case (r_state)
                OFF: begin
                    // Counters are idle, so a legal config can go live directly.
                    if (w_accept) begin
                        r_jbus_act <= w_jbus_offer;
                        r_dram_act <= w_dram_offer;
                    end
                    if (en) begin
                        r_state <= RUN;
                    end
                    r_cfg_rdy <= 1'b1;
                end
                RUN: begin
                    if (!en) begin
                        // Falling en wins; an accepted config is applied as OFF would.
                        if (w_accept) begin
                            r_jbus_act <= w_jbus_offer;
                            r_dram_act <= w_dram_offer;
                        end
                        r_state   <= OFF;
                        r_cfg_rdy <= 1'b1;
                    end else if (w_accept) begin
                        r_jbus_shd <= w_jbus_offer;
                        r_dram_shd <= w_dram_offer;
                        r_state    <= PEND;
                        r_cfg_rdy  <= 1'b0;
                    end else begin
                        r_cfg_rdy <= 1'b1;
                    end
                end
                PEND: begin
                    if (!en) begin
                        r_jbus_act <= r_jbus_shd;
                        r_dram_act <= r_dram_shd;
                        r_state    <= OFF;
                        r_cfg_rdy  <= 1'b1;
                    end else if (w_boundary) begin
                        // Both channels wrap together here, so the swap lands
                        // on a clean period start for every consumer.
                        r_jbus_act <= r_jbus_shd;
                        r_dram_act <= r_dram_shd;
                        r_state    <= RUN;
                        r_cfg_rdy  <= 1'b1;
                    end else begin
                        r_cfg_rdy <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= OFF;
                    r_cfg_rdy <= 1'b1;
                end
            endcase
        end
    end

    assign cfg_rdy      = r_cfg_rdy;
    assign cfg_err      = r_cfg_err;
    assign sync_running = w_running;

endmodule
